// File: rtl/floor_call_decoder.sv
// Elevator call-button decoder: request handshake, pending-call register,
// one-hot floor lamp and above/below call summaries.
module floor_call_decoder #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  output logic                  req_ack,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] calls,
  output logic [NUM_FLOORS-1:0] lamp,
  output logic                  floor_err,
  output logic                  pending,
  output logic                  call_above,
  output logic                  call_below
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  localparam logic [FLOOR_W:0]      FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);
  localparam logic [NUM_FLOORS-1:0] LAMP_FLOOR0 = NUM_FLOORS'(1);

  state_t state_reg, state_next;

  logic                  accept;
  logic                  req_in_range;
  logic                  floor_in_range;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;
  logic [NUM_FLOORS-1:0] lamp_decode;
  logic [NUM_FLOORS-1:0] calls_next;
  logic [NUM_FLOORS-1:0] below_lamp_mask;
  logic [NUM_FLOORS-1:0] above_lamp_mask;

  assign accept         = (state_reg == IDLE) && req_valid;
  assign req_in_range   = ({1'b0, req_floor} < FLOOR_LIMIT);
  assign floor_in_range = ({1'b0, current_floor} < FLOOR_LIMIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid)  state_next = ACK;
      ACK:     if (!req_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ack = (state_reg == ACK);

  // Out-of-range floor numbers match no decode bit, so they can never set or clear a call.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_decode
    assign set_vec[gi]     = accept && (req_floor == FLOOR_W'(gi));
    assign lamp_decode[gi] = (current_floor == FLOOR_W'(gi));
    assign clr_vec[gi]     = door_open && lamp_decode[gi];
  end

  // Clear wins over set on the same bit.
  assign calls_next = (calls | set_vec) & ~clr_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      req_err   <= 1'b0;
      calls     <= '0;
      lamp      <= LAMP_FLOOR0;
      floor_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_err   <= accept && !req_in_range;
      calls     <= calls_next;
      floor_err <= !floor_in_range;
      if (floor_in_range) begin
        lamp <= lamp_decode;
      end
    end
  end

  // below_lamp_mask[i]: lamp position lies strictly below floor i; above_lamp_mask mirrors it.
  assign below_lamp_mask[0]              = 1'b0;
  assign above_lamp_mask[NUM_FLOORS-1]   = 1'b0;
  for (genvar gi = 1; gi < NUM_FLOORS; gi++) begin : g_below
    assign below_lamp_mask[gi] = below_lamp_mask[gi-1] | lamp[gi-1];
  end
  for (genvar gi = 0; gi < NUM_FLOORS - 1; gi++) begin : g_above
    assign above_lamp_mask[gi] = above_lamp_mask[gi+1] | lamp[gi+1];
  end

  assign pending    = |calls;
  assign call_above = |(calls & below_lamp_mask);
  assign call_below = |(calls & above_lamp_mask);

endmodule

// File: tb/tb_floor_call_decoder.sv
// Directed testbench for floor_call_decoder; each task drives one scenario
// and checks hand-computed results one clock after the relevant edge.
module tb_floor_call_decoder;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_floor;
  logic [3:0] current_floor;
  logic       door_open;
  logic       req_ack;
  logic       req_err;
  logic [9:0] calls;
  logic [9:0] lamp;
  logic       floor_err;
  logic       pending;
  logic       call_above;
  logic       call_below;

  int checks = 0;
  int errors = 0;

  floor_call_decoder #(.NUM_FLOORS(10), .FLOOR_W(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .current_floor(current_floor), .door_open(door_open), .req_ack(req_ack),
    .req_err(req_err), .calls(calls), .lamp(lamp), .floor_err(floor_err),
    .pending(pending), .call_above(call_above), .call_below(call_below)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle request strobe, then release so the handshake returns to IDLE.
  task automatic do_request(input logic [3:0] f);
    @(negedge clock);
    req_floor = f;
    req_valid = 1'b1;
    tick();
    @(negedge clock);
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_floor = 4'd0;
    current_floor = 4'd0; door_open = 1'b0;
    #12;
    checks++; if (req_ack !== 1'b0)    begin errors++; $display("FAIL rst_ack got %b exp 0", req_ack); end
    checks++; if (req_err !== 1'b0)    begin errors++; $display("FAIL rst_err got %b exp 0", req_err); end
    checks++; if (calls !== 10'h000)   begin errors++; $display("FAIL rst_calls got %h exp 000", calls); end
    checks++; if (lamp !== 10'h001)    begin errors++; $display("FAIL rst_lamp got %h exp 001", lamp); end
    checks++; if (floor_err !== 1'b0)  begin errors++; $display("FAIL rst_floor_err got %b exp 0", floor_err); end
    checks++; if ({pending, call_above, call_below} !== 3'b000)
      begin errors++; $display("FAIL rst_summary got %b exp 000", {pending, call_above, call_below}); end
    @(negedge clock);
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_request();
    @(negedge clock);
    req_floor = 4'd7;
    req_valid = 1'b1;
    tick();
    checks++; if (calls !== 10'h080) begin errors++; $display("FAIL req_calls got %h exp 080", calls); end
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL req_ack_rise got %b exp 1", req_ack); end
    checks++; if (req_err !== 1'b0)  begin errors++; $display("FAIL req_no_err got %b exp 0", req_err); end
    tick();
    tick();
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL req_ack_hold got %b exp 1", req_ack); end
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL req_ack_before_drop got %b exp 1", req_ack); end
    tick();
    checks++; if (req_ack !== 1'b0)  begin errors++; $display("FAIL req_ack_fall got %b exp 0", req_ack); end
    checks++; if ({pending, call_above, call_below} !== 3'b110)
      begin errors++; $display("FAIL req_summary got %b exp 110", {pending, call_above, call_below}); end
    $display("test_request done calls=%h", calls);
  endtask

  task automatic test_invalid();
    @(negedge clock);
    req_floor = 4'd12;
    req_valid = 1'b1;
    tick();
    checks++; if (req_err !== 1'b1)  begin errors++; $display("FAIL inv_err_pulse got %b exp 1", req_err); end
    checks++; if (calls !== 10'h080) begin errors++; $display("FAIL inv_calls got %h exp 080", calls); end
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL inv_ack got %b exp 1", req_ack); end
    tick();
    checks++; if (req_err !== 1'b0)  begin errors++; $display("FAIL inv_err_one_cycle got %b exp 0", req_err); end
    @(negedge clock);
    req_valid = 1'b0;
    tick();
    checks++; if (req_ack !== 1'b0)  begin errors++; $display("FAIL inv_ack_fall got %b exp 0", req_ack); end
    $display("test_invalid done calls=%h", calls);
  endtask

  task automatic test_service();
    @(negedge clock);
    current_floor = 4'd7;
    door_open = 1'b1;
    tick();
    checks++; if (calls !== 10'h000) begin errors++; $display("FAIL svc_clear7 got %h exp 000", calls); end
    @(negedge clock);
    door_open = 1'b0;
    do_request(4'd2);
    do_request(4'd5);
    checks++; if (calls !== 10'h024) begin errors++; $display("FAIL svc_setup got %h exp 024", calls); end
    @(negedge clock);
    current_floor = 4'd5;
    door_open = 1'b1;
    tick();
    checks++; if (calls !== 10'h004) begin errors++; $display("FAIL svc_calls got %h exp 004", calls); end
    checks++; if (lamp !== 10'h020)  begin errors++; $display("FAIL svc_lamp got %h exp 020", lamp); end
    checks++; if ({pending, call_above, call_below} !== 3'b101)
      begin errors++; $display("FAIL svc_summary got %b exp 101", {pending, call_above, call_below}); end
    @(negedge clock);
    door_open = 1'b0;
    $display("test_service done calls=%h lamp=%h", calls, lamp);
  endtask

  task automatic test_collision();
    @(negedge clock);
    current_floor = 4'd3;
    door_open = 1'b1;
    req_floor = 4'd3;
    req_valid = 1'b1;
    tick();
    checks++; if (calls !== 10'h004) begin errors++; $display("FAIL col_same_bit got %h exp 004", calls); end
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL col_ack got %b exp 1", req_ack); end
    @(negedge clock);
    req_valid = 1'b0;
    door_open = 1'b0;
    tick();
    @(negedge clock);
    current_floor = 4'd2;
    door_open = 1'b1;
    req_floor = 4'd6;
    req_valid = 1'b1;
    tick();
    checks++; if (calls !== 10'h040) begin errors++; $display("FAIL col_diff_bits got %h exp 040", calls); end
    checks++; if ({pending, call_above, call_below} !== 3'b110)
      begin errors++; $display("FAIL col_summary got %b exp 110", {pending, call_above, call_below}); end
    @(negedge clock);
    req_valid = 1'b0;
    door_open = 1'b0;
    tick();
    $display("test_collision done calls=%h", calls);
  endtask

  task automatic test_bad_position();
    @(negedge clock);
    current_floor = 4'd4;
    tick();
    checks++; if (lamp !== 10'h010)  begin errors++; $display("FAIL pos_lamp4 got %h exp 010", lamp); end
    @(negedge clock);
    current_floor = 4'hF;
    door_open = 1'b1;
    tick();
    checks++; if (lamp !== 10'h010)  begin errors++; $display("FAIL pos_lamp_hold got %h exp 010", lamp); end
    checks++; if (floor_err !== 1'b1) begin errors++; $display("FAIL pos_floor_err got %b exp 1", floor_err); end
    checks++; if (calls !== 10'h040) begin errors++; $display("FAIL pos_calls_kept got %h exp 040", calls); end
    @(negedge clock);
    current_floor = 4'd2;
    door_open = 1'b0;
    tick();
    checks++; if (lamp !== 10'h004)  begin errors++; $display("FAIL pos_lamp2 got %h exp 004", lamp); end
    checks++; if (floor_err !== 1'b0) begin errors++; $display("FAIL pos_floor_err_clr got %b exp 0", floor_err); end
    $display("test_bad_position done lamp=%h", lamp);
  endtask

  task automatic test_reset_mid_ack();
    for (int f = 0; f < 10; f++) begin
      do_request(4'(f));
    end
    checks++; if (calls !== 10'h3FF) begin errors++; $display("FAIL rma_fill got %h exp 3ff", calls); end
    @(negedge clock);
    req_floor = 4'd1;
    req_valid = 1'b1;
    tick();
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL rma_ack got %b exp 1", req_ack); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (req_ack !== 1'b0)  begin errors++; $display("FAIL rma_async_ack got %b exp 0", req_ack); end
    checks++; if (calls !== 10'h000) begin errors++; $display("FAIL rma_async_calls got %h exp 000", calls); end
    checks++; if (lamp !== 10'h001)  begin errors++; $display("FAIL rma_async_lamp got %h exp 001", lamp); end
    checks++; if ({req_err, floor_err, pending} !== 3'b000)
      begin errors++; $display("FAIL rma_async_flags got %b exp 000", {req_err, floor_err, pending}); end
    tick();
    checks++; if (req_ack !== 1'b0)  begin errors++; $display("FAIL rma_held_ack got %b exp 0", req_ack); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    checks++; if (req_ack !== 1'b1)  begin errors++; $display("FAIL rma_reaccept_ack got %b exp 1", req_ack); end
    checks++; if (calls !== 10'h002) begin errors++; $display("FAIL rma_reaccept_calls got %h exp 002", calls); end
    checks++; if (lamp !== 10'h004)  begin errors++; $display("FAIL rma_lamp got %h exp 004", lamp); end
    @(negedge clock);
    req_valid = 1'b0;
    tick();
    checks++; if (req_ack !== 1'b0)  begin errors++; $display("FAIL rma_ack_fall got %b exp 0", req_ack); end
    $display("test_reset_mid_ack done calls=%h", calls);
  endtask

  initial begin
    test_reset();
    test_request();
    test_invalid();
    test_service();
    test_collision();
    test_bad_position();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floor_call_decoder.md
FLOOR_CALL_DECODER -- requirements
Module: floor_call_decoder

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 10, giving the number of floors served (floors 0..NUM_FLOORS-1).
REQ-002 The block SHALL have parameter FLOOR_W, default 4, giving the binary floor-number width.
REQ-003 clock  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clock.
REQ-005 req_valid  input  1  call request strobe from keypad/hall buttons; 4-phase handshake with req_ack.
REQ-006 req_floor  input  FLOOR_W  binary floor number of the requested call; stable while req_valid=1.
REQ-007 current_floor  input  FLOOR_W  binary floor number where the car is (from the floor encoder).
REQ-008 door_open  input  1  car is stopped with doors open at current_floor.
REQ-009 req_ack  output  1  handshake acknowledge.
REQ-010 req_err  output  1  one-cycle pulse: accepted request had req_floor >= NUM_FLOORS.
REQ-011 calls  output  NUM_FLOORS  registered pending-call vector, bit i = call pending at floor i.
REQ-012 lamp  output  NUM_FLOORS  registered one-hot position indicator of current_floor.
REQ-013 floor_err  output  1  registered flag: current_floor >= NUM_FLOORS was sampled last cycle.
REQ-014 pending  output  1  OR of calls.
REQ-015 call_above  output  1  any calls bit set at index > lamp position.
REQ-016 call_below  output  1  any calls bit set at index < lamp position.

Function
REQ-017 The request handshake SHALL be an FSM with states IDLE and ACK; req_ack=1 exactly when state=ACK.
REQ-018 In IDLE with req_valid=1 the block SHALL accept the request on that edge and enter ACK; req_ack rises the following cycle (latency 1).
REQ-019 In ACK the block SHALL remain while req_valid=1 and return to IDLE on the first edge with req_valid=0; no request is accepted in ACK.
REQ-020 On acceptance with req_floor < NUM_FLOORS, calls[req_floor] SHALL be set on the accepting edge; an already-set bit stays set.
REQ-021 On acceptance with req_floor >= NUM_FLOORS, calls SHALL be unchanged and req_err SHALL pulse high for exactly the cycle following acceptance; the FSM still enters ACK.
REQ-022 Every edge with door_open=1 and current_floor < NUM_FLOORS SHALL clear calls[current_floor].
REQ-023 Simultaneous set and clear of the same bit SHALL resolve to clear; set and clear of different bits SHALL both take effect.
REQ-024 Every edge with current_floor < NUM_FLOORS SHALL load lamp with the one-hot decode of current_floor and clear floor_err.
REQ-025 Every edge with current_floor >= NUM_FLOORS SHALL hold lamp unchanged and set floor_err; door_open clears nothing on such an edge.
REQ-026 pending, call_above and call_below SHALL be combinational from calls and lamp only, with no additional latency.
REQ-027 lamp SHALL always be exactly one-hot; calls SHALL never have a bit at index >= NUM_FLOORS.

Reset
REQ-028 While reset=0 the block SHALL hold: state=IDLE, req_ack=0, req_err=0, calls=0, lamp=one-hot floor 0 (bit 0 set), floor_err=0.
REQ-029 Reset asserted mid-handshake SHALL abort to IDLE; after release, req_valid still high SHALL be accepted as a new request on the first clock edge.
REQ-030 Pending calls SHALL be lost on reset.

Verification
REQ-031 Request: req_floor=7, req_valid pulse held 3 cycles, then low -> calls=0x080 after the accepting edge; req_ack high from the next cycle until the cycle after req_valid drops; a single acceptance.
REQ-032 Invalid: req_floor=12 -> req_err one-cycle pulse, calls unchanged, req_ack handshake completes normally.
REQ-033 Service: calls=0x024, current_floor=5, door_open=1 for one edge -> calls=0x004, lamp=0x020, call_below=1, call_above=0, pending=1.
REQ-034 Collision: req_floor=3 accepted on the same edge as current_floor=3 with door_open=1 -> calls[3]=0, req_ack still asserted.
REQ-035 Bad position: current_floor=0xF after lamp=0x010 -> lamp stays 0x010, floor_err=1; next edge with current_floor=2 -> lamp=0x004, floor_err=0.
REQ-036 Reset mid-ACK with calls=0x3FF -> all outputs immediately at REQ-028 values without a clock edge; req_valid high at release -> re-accepted on the first edge.
